atm_ledger_responder: RTL and testbench

//  Bank-side account ledger that serves the ATM controller's transactions: LOOKUP, AUTH,

---
 rtl/atm_ledger_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_atm_ledger_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger_responder.sv
// atm_ledger_responder: register-file account ledger serving ATM transactions over valid/ready.
// Optional PIN-failure lockout is compiled in by defining LEDGER_LOCKOUT_EN.
module atm_ledger_responder #(
    parameter int NUM_ACCTS     = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int REG_WIDTH     = 12,
    parameter int AMT_WIDTH     = 8,
    parameter int MAX_PIN_FAILS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [IDX_WIDTH-1:0] cfg_idx,
    input  logic [REG_WIDTH-1:0] cfg_acct,
    input  logic [REG_WIDTH-1:0] cfg_pin,
    input  logic [REG_WIDTH-1:0] cfg_bal,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [REG_WIDTH-1:0] req_acct,
    input  logic [REG_WIDTH-1:0] req_pin,
    input  logic [REG_WIDTH-1:0] req_dst,
    input  logic [AMT_WIDTH-1:0] req_amount,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_status,
    output logic [REG_WIDTH-1:0] rsp_balance,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, SRCH_SRC, SRCH_DST, EXEC, RESP} state_t;
    typedef enum logic [2:0] {
        OP_LOOKUP, OP_AUTH, OP_BALANCE, OP_DEPOSIT, OP_WITHDRAW, OP_TRANSFER
    } op_t;
    typedef enum logic [2:0] {
        ST_OK, ST_NO_ACCT, ST_BAD_PIN, ST_INSUFF, ST_NO_DST, ST_LOCKED, ST_BAD_OP, ST_OVFL
    } status_t;

    if (IDX_WIDTH != $clog2(NUM_ACCTS) || MAX_PIN_FAILS < 1) begin : g_param_check
        $error("atm_ledger_responder: inconsistent parameters");
    end

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] acct_q [NUM_ACCTS];
    logic [REG_WIDTH-1:0] pin_q  [NUM_ACCTS];
    logic [REG_WIDTH-1:0] bal_q  [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] vld_q;

    logic [2:0]           op_q;
    logic [REG_WIDTH-1:0] r_acct_q, r_pin_q, r_dst_q, amt_q;
    logic [IDX_WIDTH-1:0] scan_q, src_q, dst_q;
    status_t              status_q;
    logic [REG_WIDTH-1:0] balance_q;

    logic handshake, op_known, scan_last, src_hit, dst_hit;
    logic src_locked, dst_locked;

    assign handshake = req_valid && req_ready;
    assign op_known  = (op_q <= OP_TRANSFER);
    assign scan_last = (scan_q == IDX_WIDTH'(NUM_ACCTS - 1));
    assign src_hit   = vld_q[scan_q] && (acct_q[scan_q] == r_acct_q);
    assign dst_hit   = vld_q[scan_q] && (acct_q[scan_q] == r_dst_q);

`ifdef LEDGER_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_PIN_FAILS + 1);
    logic [NUM_ACCTS-1:0][FAIL_W-1:0] fail_q;

    assign src_locked = (fail_q[src_q] >= FAIL_W'(MAX_PIN_FAILS));
    assign dst_locked = (fail_q[dst_q] >= FAIL_W'(MAX_PIN_FAILS));
`else
    assign src_locked = 1'b0;
    assign dst_locked = 1'b0;
`endif

    // EXEC evaluation: every ledger write is decided here and committed on one edge
    logic [REG_WIDTH-1:0] src_bal, dst_bal, src_new, dst_new, ex_balance;
    logic [REG_WIDTH:0]   src_sum, dst_sum;
    logic                 src_we, dst_we;
    status_t              ex_status;

    always_comb begin
        src_bal   = bal_q[src_q];
        dst_bal   = bal_q[dst_q];
        src_sum   = {1'b0, src_bal} + {1'b0, amt_q};
        dst_sum   = {1'b0, dst_bal} + {1'b0, amt_q};
        src_new   = src_bal;
        dst_new   = dst_bal;
        src_we    = 1'b0;
        dst_we    = 1'b0;
        ex_status = ST_OK;
        if (op_q == OP_LOOKUP) begin
            ex_status = ST_OK;
        end else if (src_locked) begin
            ex_status = ST_LOCKED;
        end else if (pin_q[src_q] != r_pin_q) begin
            ex_status = ST_BAD_PIN;
        end else begin
            case (op_q)
                OP_DEPOSIT: begin
                    if (src_sum[REG_WIDTH]) begin
                        ex_status = ST_OVFL;
                    end else begin
                        src_new = src_sum[REG_WIDTH-1:0];
                        src_we  = (amt_q != '0);
                    end
                end
                OP_WITHDRAW: begin
                    if (amt_q > src_bal) begin
                        ex_status = ST_INSUFF;
                    end else begin
                        src_new = src_bal - amt_q;
                        src_we  = (amt_q != '0);
                    end
                end
                OP_TRANSFER: begin
                    if (dst_locked) begin
                        ex_status = ST_LOCKED;
                    end else if (amt_q > src_bal) begin
                        ex_status = ST_INSUFF;
                    end else if (src_q != dst_q) begin
                        if (dst_sum[REG_WIDTH]) begin
                            ex_status = ST_OVFL;
                        end else begin
                            src_new = src_bal - amt_q;
                            dst_new = dst_sum[REG_WIDTH-1:0];
                            src_we  = (amt_q != '0);
                            dst_we  = (amt_q != '0);
                        end
                    end
                end
                default: ;
            endcase
        end
        ex_balance = (ex_status == ST_OK || ex_status == ST_INSUFF) ? src_new : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (handshake) state_d = SRCH_SRC;
            SRCH_SRC: begin
                if (!op_known)      state_d = RESP;
                else if (src_hit)   state_d = (op_q == OP_TRANSFER) ? SRCH_DST : EXEC;
                else if (scan_last) state_d = RESP;
            end
            SRCH_DST: begin
                if (dst_hit)        state_d = EXEC;
                else if (scan_last) state_d = RESP;
            end
            EXEC:     state_d = RESP;
            RESP:     if (rsp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                req_ready = !cfg_we && !rst;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_status  = status_q;
    assign rsp_balance = balance_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            status_q  <= ST_OK;
            balance_q <= '0;
            scan_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        acct_q[cfg_idx] <= cfg_acct;
                        pin_q[cfg_idx]  <= cfg_pin;
                        bal_q[cfg_idx]  <= cfg_bal;
                        vld_q[cfg_idx]  <= 1'b1;
                    end
                    if (handshake) begin
                        op_q     <= req_op;
                        r_acct_q <= req_acct;
                        r_pin_q  <= req_pin;
                        r_dst_q  <= req_dst;
                        amt_q    <= REG_WIDTH'(req_amount);
                        scan_q   <= '0;
                    end
                end
                SRCH_SRC: begin
                    if (!op_known) begin
                        status_q  <= ST_BAD_OP;
                        balance_q <= '0;
                    end else if (src_hit) begin
                        src_q  <= scan_q;
                        scan_q <= '0;
                    end else if (scan_last) begin
                        status_q  <= ST_NO_ACCT;
                        balance_q <= '0;
                    end else begin
                        scan_q <= scan_q + IDX_WIDTH'(1);
                    end
                end
                SRCH_DST: begin
                    if (dst_hit) begin
                        dst_q <= scan_q;
                    end else if (scan_last) begin
                        status_q  <= ST_NO_DST;
                        balance_q <= '0;
                    end else begin
                        scan_q <= scan_q + IDX_WIDTH'(1);
                    end
                end
                EXEC: begin
                    status_q  <= ex_status;
                    balance_q <= ex_balance;
                    if (src_we) bal_q[src_q] <= src_new;
                    if (dst_we) bal_q[dst_q] <= dst_new;
                end
                default: ;
            endcase
        end
    end

`ifdef LEDGER_LOCKOUT_EN
    // Locked entries are frozen: only a preload or reset clears their counter
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q <= '0;
        end else if (state_q == IDLE && cfg_we) begin
            fail_q[cfg_idx] <= '0;
        end else if (state_q == EXEC && op_q != OP_LOOKUP && !src_locked) begin
            if (ex_status == ST_BAD_PIN) fail_q[src_q] <= fail_q[src_q] + FAIL_W'(1);
            else                         fail_q[src_q] <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_atm_ledger_responder.sv
// Randomized self-checking bench for atm_ledger_responder against an account-level reference model.
// Honours LEDGER_LOCKOUT_EN the same way the design does.
module tb_atm_ledger_responder;

    localparam int NUM_ACCTS = 4;
    localparam int IDX_WIDTH = 2;
    localparam int REG_WIDTH = 12;
    localparam int AMT_WIDTH = 8;
    localparam int MAX_FAILS = 3;
    localparam int BAL_MAX   = (1 << REG_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_we = 1'b0;
    logic [IDX_WIDTH-1:0] cfg_idx = '0;
    logic [REG_WIDTH-1:0] cfg_acct = '0, cfg_pin = '0, cfg_bal = '0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [2:0]           req_op = '0;
    logic [REG_WIDTH-1:0] req_acct = '0, req_pin = '0, req_dst = '0;
    logic [AMT_WIDTH-1:0] req_amount = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [2:0]           rsp_status;
    logic [REG_WIDTH-1:0] rsp_balance;
    logic                 busy;

    always #5 clk = ~clk;

    atm_ledger_responder #(
        .NUM_ACCTS(NUM_ACCTS), .IDX_WIDTH(IDX_WIDTH), .REG_WIDTH(REG_WIDTH),
        .AMT_WIDTH(AMT_WIDTH), .MAX_PIN_FAILS(MAX_FAILS)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acct(cfg_acct), .cfg_pin(cfg_pin), .cfg_bal(cfg_bal),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_acct(req_acct),
        .req_pin(req_pin), .req_dst(req_dst), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_balance(rsp_balance), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference ledger
    int m_acct [NUM_ACCTS];
    int m_pin  [NUM_ACCTS];
    int m_bal  [NUM_ACCTS];
    int m_fail [NUM_ACCTS];
    bit m_vld  [NUM_ACCTS];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int find(input int a);
        for (int i = 0; i < NUM_ACCTS; i++)
            if (m_vld[i] && m_acct[i] == a) return i;
        return -1;
    endfunction

    function automatic bit locked(input int i);
`ifdef LEDGER_LOCKOUT_EN
        return m_fail[i] >= MAX_FAILS;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ACCTS; i++) begin
            m_vld[i]  = 1'b0;
            m_fail[i] = 0;
        end
    endtask

    // Expected status, balance and cycles from request handshake to rsp_valid
    task automatic model_txn(input int op, input int acct, input int pin, input int dst, input int amt,
                             output int st, output int bal, output int lat);
        int s, d, sb;
        bal = 0;
        s = find(acct);
        if (op > 5) begin st = 6; lat = 1; return; end
        if (s < 0) begin st = 1; lat = NUM_ACCTS; return; end
        d = s;
        lat = s + 2;
        if (op == 5) begin
            d = find(dst);
            if (d < 0) begin st = 4; lat = s + 1 + NUM_ACCTS; return; end
            lat = s + d + 3;
        end
        sb = m_bal[s];
        if (op == 0) begin st = 0; bal = sb; return; end
        if (locked(s)) begin st = 5; return; end
        if (pin != m_pin[s]) begin st = 2; m_fail[s]++; return; end
        m_fail[s] = 0;
        st = 0;
        case (op)
            3: if (sb + amt > BAL_MAX) st = 7; else m_bal[s] = sb + amt;
            4: if (amt > sb) st = 3; else m_bal[s] = sb - amt;
            5: begin
                if (locked(d)) st = 5;
                else if (amt > sb) st = 3;
                else if (s != d) begin
                    if (m_bal[d] + amt > BAL_MAX) st = 7;
                    else begin
                        m_bal[s] = sb - amt;
                        m_bal[d] = m_bal[d] + amt;
                    end
                end
            end
            default: ;
        endcase
        if (st == 0 || st == 3) bal = m_bal[s];
    endtask

    task automatic cfg_write(input int idx, input int acct, input int pin, input int bal);
        cfg_we   = 1'b1;
        cfg_idx  = IDX_WIDTH'(idx);
        cfg_acct = REG_WIDTH'(acct);
        cfg_pin  = REG_WIDTH'(pin);
        cfg_bal  = REG_WIDTH'(bal);
        #1;
        check_eq("cfg_blocks_req_ready", req_ready, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_acct[idx] = acct;
        m_pin[idx]  = pin;
        m_bal[idx]  = bal;
        m_vld[idx]  = 1'b1;
        m_fail[idx] = 0;
    endtask

    task automatic do_txn(input int op, input int acct, input int pin, input int dst, input int amt,
                          input int hold, input bit poke, output int got_st, output int got_bal);
        int e_st, e_bal, e_lat, lat, waitc;
        model_txn(op, acct, pin, dst, amt, e_st, e_bal, e_lat);
        req_valid  = 1'b1;
        req_op     = 3'(op);
        req_acct   = REG_WIDTH'(acct);
        req_pin    = REG_WIDTH'(pin);
        req_dst    = REG_WIDTH'(dst);
        req_amount = AMT_WIDTH'(amt);
        #1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
        check_eq("req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("latency", lat, e_lat);
        check_eq("status", rsp_status, e_st);
        check_eq("balance", rsp_balance, e_bal);
        got_st  = rsp_status;
        got_bal = rsp_balance;
        for (int i = 0; i < hold; i++) begin
            cfg_we   = poke;
            cfg_idx  = '0;
            cfg_acct = 12'h123;
            cfg_bal  = 12'hABC;
            @(posedge clk); #1;
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_status", rsp_status, e_st);
            check_eq("hold_balance", rsp_balance, e_bal);
            check_eq("hold_req_ready", req_ready, 0);
        end
        cfg_we    = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("idle_after_rsp", busy, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, bl, exp_st;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_status", rsp_status, 0);
        check_eq("rst_balance", rsp_balance, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;

        cfg_write(0, 'h123, 'h456, 100);
        do_txn(3, 'h123, 'h456, 0, 20, 0, 0, st, bl);
        check_eq("dep_status", st, 0);
        check_eq("dep_balance", bl, 120);
        do_txn(4, 'h123, 'h456, 0, 150, 0, 0, st, bl);
        check_eq("wd_insuff", st, 3);
        check_eq("wd_insuff_bal", bl, 120);
        do_txn(4, 'h123, 'h456, 0, 120, 0, 0, st, bl);
        check_eq("wd_all_bal", bl, 0);
        do_txn(3, 'h123, 'h456, 0, 40, 0, 0, st, bl);
        cfg_write(3, 'h777, 'h888, 10);
        do_txn(5, 'h123, 'h456, 'h777, 5, 0, 0, st, bl);
        check_eq("xfer_status", st, 0);
        check_eq("xfer_src_bal", bl, 35);
        do_txn(2, 'h777, 'h888, 0, 0, 0, 0, st, bl);
        check_eq("xfer_dst_bal", bl, 15);
        do_txn(5, 'h123, 'h456, 'h999, 5, 0, 0, st, bl);
        check_eq("xfer_no_dst", st, 4);

        // Backpressure with an ignored preload attempt while busy
        do_txn(2, 'h123, 'h456, 0, 0, 5, 1, st, bl);
        do_txn(2, 'h123, 'h456, 0, 0, 0, 0, st, bl);
        check_eq("busy_cfg_ignored", bl, 35);
        do_txn(6, 'h123, 'h456, 0, 0, 0, 0, st, bl);
        do_txn(4, 'h123, 'h456, 0, 0, 0, 0, st, bl);

        // Reset while searching
        req_valid = 1'b1; req_op = 3'd0; req_acct = 12'h555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_srch_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_req_ready", req_ready, 0);
        check_eq("mid_rst_status", rsp_status, 0);
        rst = 1'b0;
        model_reset();
        do_txn(0, 'h123, 0, 0, 0, 0, 0, st, bl);
        check_eq("post_rst_no_acct", st, 1);

        cfg_write(1, 'h200, 'h111, 'hFF0);
        do_txn(3, 'h200, 'h111, 0, 'h20, 0, 0, st, bl);
        check_eq("dep_ovfl", st, 7);
        do_txn(2, 'h200, 'h111, 0, 0, 0, 0, st, bl);
        check_eq("ovfl_no_write", bl, 'hFF0);
        cfg_write(2, 'h300, 'h111, 'hFFE);
        do_txn(5, 'h200, 'h111, 'h300, 5, 0, 0, st, bl);
        check_eq("xfer_ovfl", st, 7);

        for (int i = 0; i < 3; i++) do_txn(1, 'h200, 'h000, 0, 0, 0, 0, st, bl);
        do_txn(1, 'h200, 'h111, 0, 0, 0, 0, st, bl);
`ifdef LEDGER_LOCKOUT_EN
        exp_st = 5;
`else
        exp_st = 0;
`endif
        check_eq("after_3_bad_pins", st, exp_st);
        do_txn(0, 'h200, 0, 0, 0, 0, 0, st, bl);
        check_eq("lookup_when_locked", bl, 'hFF0);
        cfg_write(1, 'h200, 'h111, 'h050);
        do_txn(1, 'h200, 'h111, 0, 0, 0, 0, st, bl);
        check_eq("unlock_by_cfg", st, 0);

        // Random traffic over a small account/PIN pool so hits, misses and duplicates all occur
        for (int i = 0; i < NUM_ACCTS; i++)
            cfg_write(i, 'h100 + $urandom_range(0, 5), ($urandom_range(0, 1) != 0) ? 'h11 : 'h22,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(3900, 4095) : $urandom_range(0, 600));
        for (int n = 0; n < 220; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                cfg_write($urandom_range(0, NUM_ACCTS - 1), 'h100 + $urandom_range(0, 5),
                          ($urandom_range(0, 1) != 0) ? 'h11 : 'h22, $urandom_range(0, 4095));
            end else begin
                do_txn(($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5),
                       'h100 + $urandom_range(0, 5),
                       'h11 * $urandom_range(1, 3),
                       'h100 + $urandom_range(0, 5),
                       ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255),
                       $urandom_range(0, 2), 1'b0, st, bl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
